// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: opcodes, the injected bubble instruction,
// and immediate decoders used by the IF-stage next-PC logic.
package riscv_pkg;

    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP           = 32'h0000_0013;

    // UJ-format immediate. The argument is inst[31:12].
    function automatic logic [31:0] uj_imm(input logic [31:12] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // RVC CJ-format immediate (C.J / C.JAL). The argument is inst[12:2].
    function automatic logic [31:0] rvc_j_imm(input logic [12:2] inst);
        return {{21{inst[12]}}, inst[8], inst[10:9], inst[6], inst[7],
                inst[2], inst[11], inst[5:3], 1'b0};
    endfunction

    // True for either unconditional compressed jump: C.J (funct3=101) or
    // C.JAL (funct3=001, RV32 only). Both are quadrant 1.
    function automatic logic is_rvc_jal(input logic [15:0] inst);
        return ((inst & 16'hE003) == 16'hA001) || ((inst & 16'hE003) == 16'h2001);
    endfunction

endpackage

// File: rtl/riscv_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Ports:
//   clk, rst_n                   clock, async active-low reset (clears valid bits)
//   lookup_pc_i                  fetch PC
//   hit_o, taken_o, target_o     combinational lookup result
//   fb_valid_i, fb_pc_i,
//   fb_taken_i, fb_target_i      resolved-branch feedback, written at the next edge
module riscv_btb #(
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] lookup_pc_i,
    output logic            hit_o,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    input  logic            fb_valid_i,
    input  logic [XLEN-1:0] fb_pc_i,
    input  logic            fb_taken_i,
    input  logic [XLEN-1:0] fb_target_i
);
    import riscv_pkg::*;

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = XLEN - IW - 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q  [BTB_ENTRIES];
    logic [TW-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

    // Halfword granularity: bit 0 of a PC never selects anything.
    logic unused_lsb;
    assign unused_lsb = lookup_pc_i[0] ^ fb_pc_i[0];

    logic [IW-1:0] l_idx, u_idx;
    logic [TW-1:0] l_tag, u_tag;
    logic          u_hit;

    assign l_idx = lookup_pc_i[IW:1];
    assign l_tag = lookup_pc_i[XLEN-1:IW+1];
    assign u_idx = fb_pc_i[IW:1];
    assign u_tag = fb_pc_i[XLEN-1:IW+1];

    assign hit_o    = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign taken_o  = hit_o && ctr_q[l_idx][CTR_BITS-1];
    assign target_o = target_q[l_idx];

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // Only the valid bits are reset; a write landing while reset is low
    // therefore never becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (fb_valid_i && !u_hit && fb_taken_i) begin
            valid_q[u_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fb_valid_i) begin
            if (u_hit) begin
                if (fb_taken_i) begin
                    target_q[u_idx] <= fb_target_i;
                    if (ctr_q[u_idx] != CTR_MAX) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + CTR_BITS'(1);
                    end
                end else if (ctr_q[u_idx] != '0) begin
                    ctr_q[u_idx] <= ctr_q[u_idx] - CTR_BITS'(1);
                end
            end else if (fb_taken_i) begin
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= fb_target_i;
                ctr_q[u_idx]    <= CTR_WEAK;
            end
        end
    end

endmodule

// File: rtl/riscv_if_bp.sv
// IF-stage next-PC unit with BTB-based dynamic prediction and static
// redirection of JAL / C.J / C.JAL. Drives the IF/ID pipeline register and
// passes the prediction down for checking in EX.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   stall, flush                     IF/ID hold / bubble; stall also holds the PC
//   make_correction, pc_correction   EX redirect (overrides stall)
//   inst_i, inst_ready,
//   inst_compressed                  aligned instruction from the realigner
//   fb_*                             resolved-branch feedback for the BTB
//   pc, step                         fetch PC, realigner advance
//   *_ppl                            IF/ID register fields
module riscv_if_bp #(
    parameter int          XLEN        = 32,
    parameter int          BTB_ENTRIES = 16,
    parameter int          CTR_BITS    = 2,
    parameter logic [31:0] NOP         = riscv_pkg::NOP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            make_correction,
    input  logic [XLEN-1:0] pc_correction,
    input  logic [31:0]     inst_i,
    input  logic            inst_ready,
    input  logic            inst_compressed,
    input  logic            fb_valid,
    input  logic [XLEN-1:0] fb_pc,
    input  logic            fb_taken,
    input  logic [XLEN-1:0] fb_target,
    output logic [XLEN-1:0] pc,
    output logic            step,
    output logic [31:0]     inst_ppl,
    output logic [XLEN-1:0] pc_ppl,
    output logic            compressed_ppl,
    output logic            pred_taken_ppl,
    output logic [XLEN-1:0] pred_target_ppl
);
    import riscv_pkg::*;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q;
    logic [XLEN-1:0] pc_ppl_q;
    logic            compressed_q;
    logic            pred_taken_q;
    logic [XLEN-1:0] pred_target_q;

    logic            bp_hit, bp_taken;
    logic [XLEN-1:0] bp_target;
    logic            is_jump;
    logic [31:0]     imm32;
    logic [XLEN-1:0] pc_step, jump_target;

    riscv_btb #(
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_BITS    (CTR_BITS),
        .XLEN        (XLEN)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_pc_i (pc_q),
        .hit_o       (bp_hit),
        .taken_o     (bp_taken),
        .target_o    (bp_target),
        .fb_valid_i  (fb_valid),
        .fb_pc_i     (fb_pc),
        .fb_taken_i  (fb_taken),
        .fb_target_i (fb_target)
    );

    logic unused_hit;
    assign unused_hit = bp_hit;

    assign is_jump = inst_compressed ? is_rvc_jal(inst_i[15:0])
                                     : (inst_i[6:0] == OPCODE_JAL);
    assign imm32   = inst_compressed ? rvc_j_imm(inst_i[12:2])
                                     : uj_imm(inst_i[31:12]);

    assign pc_step     = pc_q + (inst_compressed ? XLEN'(2) : XLEN'(4));
    assign jump_target = pc_q + XLEN'(signed'(imm32));

    always_comb begin
        pc_d = pc_step;
        if (make_correction) begin
            pc_d = pc_correction;
        end else if (stall || !inst_ready) begin
            pc_d = pc_q;
        end else if (is_jump) begin
            pc_d = jump_target;
        end else if (bp_taken) begin
            pc_d = bp_target;
        end
    end

    assign step = !make_correction && !stall && inst_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Stall takes precedence over flush so a held bubble keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q        <= NOP;
            pc_ppl_q      <= '0;
            compressed_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else if (!stall) begin
            pc_ppl_q      <= pc_q;
            pred_target_q <= pc_d;
            if (flush || !inst_ready) begin
                inst_q       <= NOP;
                compressed_q <= 1'b0;
                pred_taken_q <= 1'b0;
            end else begin
                inst_q       <= inst_i;
                compressed_q <= inst_compressed;
                pred_taken_q <= is_jump || bp_taken;
            end
        end
    end

    assign pc              = pc_q;
    assign inst_ppl        = inst_q;
    assign pc_ppl          = pc_ppl_q;
    assign compressed_ppl  = compressed_q;
    assign pred_taken_ppl  = pred_taken_q;
    assign pred_target_ppl = pred_target_q;

endmodule
